// File: rtl/lexington_pkg.sv
// Shared AXI definitions for the lexington bus fabric: response codes and
// default bridge sizing.
package lexington_pkg;

  localparam int DEFAULT_AXI_ADDR_WIDTH = 32;
  localparam int DEFAULT_AXI_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  // EXOKAY is a success for a single-beat lite access; only the error codes fault.
  function automatic logic resp_is_fault(input axi_resp_t resp);
    return (resp == SLVERR) || (resp == DECERR);
  endfunction

endpackage

// File: rtl/axi_lite_master.sv
// Bridges the core's single-cycle DBus request port onto an AXI4-Lite master,
// stalling the core with busy until the B/R response (or a timeout) returns.
module axi_lite_master
  import lexington_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_AXI_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_en,
  input  logic                      wr_en,
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  input  logic [31:0]               wr_data,
  input  logic [3:0]                wr_strobe,
  output logic [31:0]               rd_data,
  output logic                      access_fault,
  output logic                      busy,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [31:0]               m_axi_wdata,
  output logic [3:0]                m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [31:0]               m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t                    state, state_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_d, araddr_d;
  logic [31:0]               wdata_d, rd_data_d;
  logic [3:0]                wstrb_d;
  logic                      awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic                      fault_d;
  logic                      stale, stale_d;
  logic [CNT_W-1:0]          cnt, cnt_d;
  logic                      expired;
  logic                      swallow;

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  // A timed-out slave may still answer later; that stray beat is absorbed here.
  assign swallow = stale && ((m_axi_bready && m_axi_bvalid) || (m_axi_rready && m_axi_rvalid));
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  always_comb begin
    busy = 1'b0;
    case (state)
      IDLE:                                busy = rd_en || wr_en;
      WR_ADDR, WR_RESP, RD_ADDR, RD_DATA:  busy = 1'b1;
      default:                             busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rd_data       <= '0;
      access_fault  <= 1'b0;
      stale         <= 1'b0;
      cnt           <= '0;
    end else begin
      state         <= state_d;
      m_axi_awaddr  <= awaddr_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wdata   <= wdata_d;
      m_axi_wstrb   <= wstrb_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
      m_axi_araddr  <= araddr_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_rready  <= rready_d;
      rd_data       <= rd_data_d;
      access_fault  <= fault_d;
      stale         <= stale_d;
      cnt           <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    awaddr_d  = m_axi_awaddr;
    awvalid_d = m_axi_awvalid;
    wdata_d   = m_axi_wdata;
    wstrb_d   = m_axi_wstrb;
    wvalid_d  = m_axi_wvalid;
    bready_d  = m_axi_bready;
    araddr_d  = m_axi_araddr;
    arvalid_d = m_axi_arvalid;
    rready_d  = m_axi_rready;
    rd_data_d = rd_data;
    fault_d   = access_fault;
    stale_d   = stale;
    cnt_d     = cnt;

    case (state)
      IDLE: begin
        if (stale) begin
          if (swallow) begin
            stale_d  = 1'b0;
            bready_d = 1'b0;
            rready_d = 1'b0;
          end
        end else if (wr_en) begin
          awaddr_d  = addr;
          wdata_d   = wr_data;
          wstrb_d   = wr_strobe;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR_ADDR;
        end else if (rd_en) begin
          araddr_d  = addr;
          arvalid_d = 1'b1;
          state_d   = RD_ADDR;
        end
      end

      // AW and W retire independently; B is only requested once both have.
      WR_ADDR: begin
        if (m_axi_awvalid && m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wvalid && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          cnt_d    = '0;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (m_axi_bvalid) begin
          fault_d  = resp_is_fault(axi_resp_t'(m_axi_bresp));
          bready_d = 1'b0;
          state_d  = DONE;
        end else if (expired) begin
          fault_d   = 1'b1;
          rd_data_d = '0;
          stale_d   = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (m_axi_rvalid) begin
          rd_data_d = m_axi_rdata;
          fault_d   = resp_is_fault(axi_resp_t'(m_axi_rresp));
          rready_d  = 1'b0;
          state_d   = DONE;
        end else if (expired) begin
          fault_d   = 1'b1;
          rd_data_d = '0;
          stale_d   = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        if (swallow) begin
          stale_d  = 1'b0;
          bready_d = 1'b0;
          rready_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a delay-configurable AXI-Lite slave plus a
// latency/result model derived from handshake delays.
module tb_axi_lite_master;
  import lexington_pkg::*;

  localparam int AW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_en, wr_en;
  logic [AW-1:0] addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strobe;
  logic [31:0]   rd_data;
  logic          access_fault, busy;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready;
  logic [31:0]   m_axi_wdata, m_axi_rdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wvalid, m_axi_wready;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic          m_axi_bvalid, m_axi_bready;
  logic          m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;

  axi_lite_master #(.AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .wr_strobe(wr_strobe), .rd_data(rd_data),
    .access_fault(access_fault), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Slave configuration for the current access
  int          cfg_aw_dly, cfg_w_dly, cfg_ar_dly, cfg_resp_dly;
  logic [1:0]  cfg_resp;
  logic [31:0] cfg_rdata;
  bit          cfg_drop;

  // Slave state and what it captured at handshakes
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit          aw_got, w_got, ar_got;
  bit          aw_hs, w_hs, ar_hs, b_hs, r_hs;
  bit          aw_pend, w_pend, ar_pend;
  int          viol = 0;
  logic [31:0] got_awaddr, got_wdata, got_araddr;
  logic [3:0]  got_wstrb;

  // Handshakes are sampled at the rising edge; the slave reacts on the falling edge.
  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; ar_got = 0;
    forever begin
      @(posedge clk);
      aw_hs = m_axi_awvalid && m_axi_awready;
      w_hs  = m_axi_wvalid && m_axi_wready;
      ar_hs = m_axi_arvalid && m_axi_arready;
      b_hs  = m_axi_bvalid && m_axi_bready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      aw_pend = m_axi_awvalid && !m_axi_awready;
      w_pend  = m_axi_wvalid && !m_axi_wready;
      ar_pend = m_axi_arvalid && !m_axi_arready;
      if (aw_hs) got_awaddr = m_axi_awaddr;
      if (w_hs) begin got_wdata = m_axi_wdata; got_wstrb = m_axi_wstrb; end
      if (ar_hs) got_araddr = m_axi_araddr;
      @(negedge clk);
      if (!rst_n) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        continue;
      end
      if (aw_pend && !m_axi_awvalid) viol++;
      if (w_pend && !m_axi_wvalid) viol++;
      if (ar_pend && !m_axi_arvalid) viol++;
      if (aw_hs) aw_got = 1;
      if (w_hs) w_got = 1;
      if (ar_hs) ar_got = 1;
      if (!m_axi_awvalid) aw_cnt = 0;
      if (!m_axi_wvalid) w_cnt = 0;
      if (!m_axi_arvalid) ar_cnt = 0;
      m_axi_awready = m_axi_awvalid && (aw_cnt >= cfg_aw_dly);
      m_axi_wready  = m_axi_wvalid && (w_cnt >= cfg_w_dly);
      m_axi_arready = m_axi_arvalid && (ar_cnt >= cfg_ar_dly);
      if (m_axi_awvalid && !m_axi_awready) aw_cnt++;
      if (m_axi_wvalid && !m_axi_wready) w_cnt++;
      if (m_axi_arvalid && !m_axi_arready) ar_cnt++;
      if (b_hs) begin
        m_axi_bvalid = 0; aw_got = 0; w_got = 0; b_cnt = 0;
      end else if (aw_got && w_got && !m_axi_bvalid && !cfg_drop) begin
        if (b_cnt >= cfg_resp_dly) begin m_axi_bvalid = 1; m_axi_bresp = cfg_resp; end
        else b_cnt++;
      end
      if (r_hs) begin
        m_axi_rvalid = 0; ar_got = 0; r_cnt = 0;
      end else if (ar_got && !m_axi_rvalid && !cfg_drop) begin
        if (r_cnt >= cfg_resp_dly) begin
          m_axi_rvalid = 1; m_axi_rresp = cfg_resp; m_axi_rdata = cfg_rdata;
        end else r_cnt++;
      end
      if (m_axi_bready && !(aw_got && w_got)) viol++;
      if (m_axi_rready && !ar_got) viol++;
    end
  end

  bit log_aw [0:63];
  bit log_w  [0:63];
  bit log_ar [0:63];
  bit log_b  [0:63];
  bit ar_seen;

  // One core access; expectations come from the slave delays alone.
  task automatic applyStimulus(input bit do_wr, input bit do_rd, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s, input string tag);
    int dly, exp_done, done_cyc, busy_cnt;
    bit tmo;
    logic exp_fault;
    logic [31:0] exp_data;
    tmo       = cfg_drop || (cfg_resp_dly >= TMO);
    dly       = do_wr ? ((cfg_aw_dly > cfg_w_dly) ? cfg_aw_dly : cfg_w_dly) : cfg_ar_dly;
    exp_done  = 3 + dly + (tmo ? TMO - 1 : cfg_resp_dly);
    exp_fault = tmo ? 1'b1 : (cfg_resp >= 2'd2);
    exp_data  = tmo ? 32'h0 : cfg_rdata;
    ar_seen   = 0;
    @(posedge clk); #1;
    wr_en = do_wr; rd_en = do_rd; addr = a; wr_data = d; wr_strobe = s;
    done_cyc = -1; busy_cnt = 0;
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      @(negedge clk); #1;
      if (c < 64) begin
        log_aw[c] = m_axi_awvalid; log_w[c] = m_axi_wvalid;
        log_ar[c] = m_axi_arvalid; log_b[c] = m_axi_bready;
      end
      if (m_axi_arvalid) ar_seen = 1;
      if (busy) busy_cnt++;
      else done_cyc = c;
    end
    if (done_cyc < 0) begin
      checkOutput({tag, "_never_done"}, 32'd1, 32'd0);
    end else begin
      checkOutput({tag, "_done_cycle"}, done_cyc, exp_done);
      checkOutput({tag, "_busy_cycles"}, busy_cnt, exp_done);
      checkOutput({tag, "_fault"}, 32'(access_fault), 32'(exp_fault));
      if (do_wr) begin
        checkOutput({tag, "_awaddr"}, got_awaddr, a);
        checkOutput({tag, "_wdata"}, got_wdata, d);
        checkOutput({tag, "_wstrb"}, 32'(got_wstrb), 32'(s));
      end else begin
        checkOutput({tag, "_rd_data"}, rd_data, exp_data);
        checkOutput({tag, "_araddr"}, got_araddr, a);
      end
    end
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0;
  endtask

  task automatic set_slave(input int aw_d, input int w_d, input int ar_d, input int r_d,
                           input logic [1:0] resp, input logic [31:0] rdata, input bit drop);
    cfg_aw_dly = aw_d; cfg_w_dly = w_d; cfg_ar_dly = ar_d; cfg_resp_dly = r_d;
    cfg_resp = resp; cfg_rdata = rdata; cfg_drop = drop;
  endtask

  initial begin
    int done_cyc;
    bit stall_ok;
    rst_n = 0; rd_en = 0; wr_en = 0; addr = 0; wr_data = 0; wr_strobe = 0;
    set_slave(0, 0, 0, 0, OKAY, 32'h0, 0);
    #2;
    checkOutput("reset_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                                     m_axi_bready, m_axi_rready}), 32'h0);
    checkOutput("reset_rd_data", rd_data, 32'h0);
    checkOutput("reset_fault", 32'(access_fault), 32'h0);
    checkOutput("reset_busy_idle", 32'(busy), 32'h0);
    rd_en = 1; #1;
    checkOutput("reset_busy_req", 32'(busy), 32'h1);
    rd_en = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Minimum-latency read
    set_slave(0, 0, 0, 0, OKAY, 32'hDEADBEEF, 0);
    applyStimulus(0, 1, 32'h0000_1000, 32'h0, 4'h0, "rd_min");
    checkOutput("rd_min_ar_c0", 32'(log_ar[0]), 32'h0);
    checkOutput("rd_min_ar_c1", 32'(log_ar[1]), 32'h1);

    // W accepted three cycles ahead of AW
    set_slave(3, 0, 0, 0, OKAY, 32'h0, 0);
    applyStimulus(1, 0, 32'h8000_0010, 32'h1234_5678, 4'b0011, "wr_skew");
    checkOutput("wr_skew_w_c2", 32'(log_w[2]), 32'h0);
    checkOutput("wr_skew_aw_c2", 32'(log_aw[2]), 32'h1);
    checkOutput("wr_skew_b_c4", 32'(log_b[4]), 32'h0);
    checkOutput("wr_skew_b_c5", 32'(log_b[5]), 32'h1);

    set_slave(0, 0, 1, 0, DECERR, 32'h5555_AAAA, 0);
    applyStimulus(0, 1, 32'h0000_2000, 32'h0, 4'h0, "rd_decerr");
    set_slave(0, 2, 0, 1, SLVERR, 32'h0, 0);
    applyStimulus(1, 0, 32'h0000_3000, 32'hCAFE_F00D, 4'hF, "wr_slverr");
    set_slave(0, 0, 0, 0, EXOKAY, 32'h0BAD_CAFE, 0);
    applyStimulus(0, 1, 32'h0000_4000, 32'h0, 4'h0, "rd_exokay");

    // Response on the expiry cycle wins; one cycle later the timeout wins
    set_slave(0, 0, 0, TMO - 1, OKAY, 32'h7777_1111, 0);
    applyStimulus(0, 1, 32'h0000_5000, 32'h0, 4'h0, "rd_resp_edge");
    set_slave(0, 0, 0, TMO, OKAY, 32'h9999_2222, 0);
    applyStimulus(0, 1, 32'h0000_6000, 32'h0, 4'h0, "rd_tmo_edge");
    set_slave(0, 0, 0, 0, OKAY, 32'h1357_9BDF, 0);
    applyStimulus(0, 1, 32'h0000_6004, 32'h0, 4'h0, "rd_after_tmo");
    set_slave(1, 0, 0, TMO, OKAY, 32'h0, 0);
    applyStimulus(1, 0, 32'h0000_7000, 32'h0101_0101, 4'h1, "wr_tmo_edge");

    // Silent slave: next request must stall until the stray beat is absorbed
    set_slave(0, 0, 0, 0, OKAY, 32'h0, 1);
    applyStimulus(0, 1, 32'h0000_8000, 32'h0, 4'h0, "rd_silent");
    @(posedge clk); #1;
    rd_en = 1; addr = 32'h0000_8004;
    stall_ok = 1;
    repeat (5) begin
      @(negedge clk); #1;
      if (!busy || m_axi_arvalid) stall_ok = 0;
    end
    checkOutput("stale_stall", 32'(stall_ok), 32'h1);
    cfg_rdata = 32'hBAD0_BAD0; cfg_drop = 0;
    @(negedge clk); #1;
    checkOutput("stale_stray_rvalid", 32'(m_axi_rvalid), 32'h1);
    cfg_rdata = 32'h0F0F_1234;
    done_cyc = -1;
    for (int c = 1; c < 50 && done_cyc < 0; c++) begin
      @(negedge clk); #1;
      if (!busy) done_cyc = c;
    end
    checkOutput("stale_resume_cycles", done_cyc, 4);
    checkOutput("stale_resume_data", rd_data, 32'h0F0F_1234);
    checkOutput("stale_resume_fault", 32'(access_fault), 32'h0);
    @(posedge clk); #1;
    rd_en = 0;

    // Both requests high: write wins, AR never issued
    set_slave(1, 1, 0, 0, OKAY, 32'h0, 0);
    applyStimulus(1, 1, 32'h0000_9000, 32'hA5A5_5A5A, 4'hC, "both");
    checkOutput("both_no_ar", 32'(ar_seen), 32'h0);

    // Asynchronous reset in the middle of WR_ADDR
    set_slave(5, 5, 0, 0, OKAY, 32'h0, 0);
    @(posedge clk); #1;
    wr_en = 1; addr = 32'h0000_A000; wr_data = 32'h1111_2222; wr_strobe = 4'hF;
    @(posedge clk); #3;
    rst_n = 0; #1;
    checkOutput("rst_mid_valids", 32'({m_axi_awvalid, m_axi_wvalid}), 32'h0);
    checkOutput("rst_mid_busy_req", 32'(busy), 32'h1);
    wr_en = 0; #1;
    checkOutput("rst_mid_busy_idle", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    set_slave(0, 0, 0, 0, OKAY, 32'h0, 0);
    applyStimulus(1, 0, 32'h0000_A004, 32'h3333_4444, 4'h3, "after_rst");

    // Randomised traffic, responses always inside the timeout window
    for (int i = 0; i < 25; i++) begin
      int kind;
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, TMO - 2), 2'($urandom_range(0, 3)), $urandom, 0);
      kind = $urandom_range(0, 2);
      applyStimulus(kind != 1, kind != 0, $urandom, $urandom, 4'($urandom), "rand");
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    checkOutput("protocol_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
